// File: rtl/rec_play_ctrl.sv
// Record/playback sequencer: paces sample-memory writes (RECORD) and DAC
// update strobes (PLAY) from a clock divider and remembers the last recording length.
module rec_play_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int SAMPLE_DIV = 2500
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rec_pulse,
  input  logic              play_pulse,
  input  logic              stop_pulse,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              play_en,
  output logic [1:0]        state,
  output logic [ADDR_W:0]   rec_len,
  output logic              done
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_MAX  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic               pe_q, pe_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic               done_q, done_d;
  logic               tick;

  assign tick = (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    addr_d  = addr_q;
    we_d    = 1'b0;
    pe_d    = 1'b0;
    len_d   = len_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        div_d  = '0;
        addr_d = '0;
        if (stop_pulse) begin
          state_d = S_IDLE;
        end else if (rec_pulse) begin
          state_d = S_RECORD;
        end else if (play_pulse && (len_q != '0)) begin
          state_d = S_PLAY;
        end
      end

      S_RECORD: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (stop_pulse) begin
          // A strobe high in this cycle has already been written, so it counts.
          state_d = S_IDLE;
          len_d   = {1'b0, addr_q} + (ADDR_W+1)'(we_q);
          addr_d  = '0;
          div_d   = '0;
          done_d  = 1'b1;
        end else if (we_q && (addr_q == '1)) begin
          state_d = S_IDLE;
          len_d   = LEN_FULL;
          addr_d  = '0;
          div_d   = '0;
          done_d  = 1'b1;
        end else begin
          if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          we_d = tick;
        end
      end

      S_PLAY: begin
        div_d = tick ? '0 : div_q + DIV_W'(1);
        if (stop_pulse || (pe_q && ({1'b0, addr_q} == len_q - (ADDR_W+1)'(1)))) begin
          state_d = S_IDLE;
          addr_d  = '0;
          div_d   = '0;
          done_d  = 1'b1;
        end else begin
          if (pe_q) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          pe_d = tick;
        end
      end

      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        addr_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      pe_q    <= 1'b0;
      len_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      pe_q    <= pe_d;
      len_q   <= len_d;
      done_q  <= done_d;
    end
  end

  assign mem_addr = addr_q;
  assign mem_we   = we_q;
  assign play_en  = pe_q;
  assign state    = state_q;
  assign rec_len  = len_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl with SAMPLE_DIV=4, ADDR_W=3.
module tb_rec_play_ctrl;

  localparam int ADDR_W     = 3;
  localparam int SAMPLE_DIV = 4;

  logic              clk;
  logic              rst;
  logic              rec_pulse, play_pulse, stop_pulse;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, play_en, done;
  logic [1:0]        state;
  logic [ADDR_W:0]   rec_len;

  int unsigned errors = 0;
  int unsigned checks = 0;

  rec_play_ctrl #(.ADDR_W(ADDR_W), .SAMPLE_DIV(SAMPLE_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .rec_pulse  (rec_pulse),
    .play_pulse (play_pulse),
    .stop_pulse (stop_pulse),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .play_en    (play_en),
    .state      (state),
    .rec_len    (rec_len),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic       rec, play, stop;
    logic [1:0] st;
    logic [2:0] addr;
    logic       we, pe;
    logic [3:0] len;
    logic       dn;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic [2:0] addr,
                         input logic we, input logic pe, input logic [3:0] len, input logic dn);
    chk({tag, ".state"},    32'(state),    32'(st));
    chk({tag, ".mem_addr"}, 32'(mem_addr), 32'(addr));
    chk({tag, ".mem_we"},   32'(mem_we),   32'(we));
    chk({tag, ".play_en"},  32'(play_en),  32'(pe));
    chk({tag, ".rec_len"},  32'(rec_len),  32'(len));
    chk({tag, ".done"},     32'(done),     32'(dn));
  endtask

  // Drive pulses for one cycle; they are sampled at the next rising edge.
  task automatic step(input logic r, input logic p, input logic s);
    @(negedge clk);
    rec_pulse  = r;
    play_pulse = p;
    stop_pulse = s;
    @(posedge clk);
    #1;
    rec_pulse  = 1'b0;
    play_pulse = 1'b0;
    stop_pulse = 1'b0;
  endtask

  vec_t vecs [7];

  initial begin
    logic       exp_we, exp_pe, exp_dn;
    logic [2:0] exp_addr;
    logic [1:0] exp_st;

    //            rec  play stop st     addr  we    pe    len   done
    vecs[0] = '{1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0}; // play with empty recording
    vecs[1] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0}; // stop wins in IDLE
    vecs[3] = '{1'b1, 1'b1, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0}; // rec beats play
    vecs[4] = '{1'b0, 1'b0, 1'b0, 2'd1, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b1}; // early stop, nothing written
    vecs[6] = '{1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0};

    rst = 1'b1;
    rec_pulse = 1'b0; play_pulse = 1'b0; stop_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      step(vecs[i].rec, vecs[i].play, vecs[i].stop);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].addr, vecs[i].we,
              vecs[i].pe, vecs[i].len, vecs[i].dn);
    end

    // Full record: strobes at cycles 5,9,..,33 with addresses 0..7; stray
    // rec/play pulses at cycles 7 and 13 must not disturb pacing.
    step(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= 34; c++) begin
      exp_we   = (c >= 5) && (c <= 33) && (((c - 5) % 4) == 0);
      exp_addr = (c <= 5 || c == 34) ? 3'd0 : 3'((c - 6) / 4 + 1);
      exp_st   = (c == 34) ? 2'd0 : 2'd1;
      exp_dn   = (c == 34);
      chk($sformatf("full_c%0d.mem_we", c),   32'(mem_we),   32'(exp_we));
      chk($sformatf("full_c%0d.mem_addr", c), 32'(mem_addr), 32'(exp_addr));
      chk($sformatf("full_c%0d.state", c),    32'(state),    32'(exp_st));
      chk($sformatf("full_c%0d.done", c),     32'(done),     32'(exp_dn));
      chk($sformatf("full_c%0d.play_en", c),  32'(play_en),  32'd0);
      if (c < 34) step(c == 7, c == 13, 1'b0);
    end
    chk("full.rec_len", 32'(rec_len), 32'd8);

    // Partial record, started back-to-back while done is high; stop during
    // the 4th strobe (addr 3) at cycle 17.
    step(1'b1, 1'b0, 1'b0);
    chk("part.start_state", 32'(state), 32'd1);
    for (int c = 1; c <= 17; c++) begin
      exp_we   = (c >= 5) && (((c - 5) % 4) == 0);
      exp_addr = (c <= 5) ? 3'd0 : 3'((c - 6) / 4 + 1);
      chk($sformatf("part_c%0d.mem_we", c),   32'(mem_we),   32'(exp_we));
      chk($sformatf("part_c%0d.mem_addr", c), 32'(mem_addr), 32'(exp_addr));
      step(1'b0, 1'b0, c == 17);
    end
    chk_all("part.stop", 2'd0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1);
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_all($sformatf("part.idle%0d", c), 2'd0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b0);
    end

    // Playback of the 4-sample recording; stray rec pulse at cycle 7.
    step(1'b0, 1'b1, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      exp_pe   = (c >= 5) && (c <= 17) && (((c - 5) % 4) == 0);
      exp_addr = (c <= 5 || c == 18) ? 3'd0 : 3'((c - 6) / 4 + 1);
      exp_st   = (c == 18) ? 2'd0 : 2'd2;
      exp_dn   = (c == 18);
      chk($sformatf("play_c%0d.play_en", c),  32'(play_en),  32'(exp_pe));
      chk($sformatf("play_c%0d.mem_addr", c), 32'(mem_addr), 32'(exp_addr));
      chk($sformatf("play_c%0d.state", c),    32'(state),    32'(exp_st));
      chk($sformatf("play_c%0d.done", c),     32'(done),     32'(exp_dn));
      chk($sformatf("play_c%0d.mem_we", c),   32'(mem_we),   32'd0);
      if (c < 18) step(c == 7, 1'b0, 1'b0);
    end
    chk("play.rec_len", 32'(rec_len), 32'd4);

    // Back-to-back play while done is high, then stop in PLAY.
    step(1'b0, 1'b1, 1'b0);
    chk_all("replay.start", 2'd2, 3'd0, 1'b0, 1'b0, 4'd4, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    chk_all("replay.stop", 2'd0, 3'd0, 1'b0, 1'b0, 4'd4, 1'b1);

    // Asynchronous reset mid-record during the strobe at addr 1.
    step(1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0, 1'b0);
    chk_all("prerst", 2'd1, 3'd1, 1'b1, 1'b0, 4'd4, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk_all("rst_hold", 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    chk_all("play_after_rst", 2'd0, 3'd0, 1'b0, 1'b0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rec_play_ctrl.md
# rec_play_ctrl

Record/playback sequencer for the audio recorder. It takes single-cycle button pulses produced by the edge detectors, paces sample transfers with a clock divider, and drives the sample-memory address and write strobe while recording. During playback it issues DAC update strobes. It also remembers the length of the last recording.

## Interface
- ADDR_W, 16, sample memory address width
- SAMPLE_DIV, 2500, clk cycles per sample period; must be ≥ 2
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rec_pulse  input  1  one-cycle pulse, start recording
- play_pulse  input  1  one-cycle pulse, start playback
- stop_pulse  input  1  one-cycle pulse, abort record/playback
- mem_addr  output  ADDR_W  sample memory address, registered
- mem_we  output  1  one-cycle write strobe (RECORD), registered
- play_en  output  1  one-cycle read/DAC-update strobe (PLAY), registered
- state  output  2  0 = IDLE, 1 = RECORD, 2 = PLAY
- rec_len  output  ADDR_W+1  samples held by last recording, 0..2^ADDR_W
- done  output  1  one-cycle pulse when RECORD or PLAY returns to IDLE, for any reason

## Operation
- Reset values: state = IDLE, mem_addr = 0, mem_we = 0, play_en = 0, rec_len = 0, done = 0, divider = 0.
- Divider: counts 0..SAMPLE_DIV-1 only in RECORD or PLAY. It is held at 0 in IDLE. A tick is the cycle where divider = SAMPLE_DIV-1, after which it wraps to 0.
- Pulse priority in any one cycle: stop > rec > play.
- IDLE:
  - rec_pulse → RECORD; mem_addr = 0.
  - play_pulse with rec_len ≠ 0 → PLAY; mem_addr = 0.
  - play_pulse with rec_len = 0 is ignored.
  - stop_pulse has no effect.
- RECORD:
  - A tick sets mem_we = 1 for the next cycle. mem_addr holds the address being written during that cycle.
  - On the edge ending a strobe cycle, mem_addr increments.
  - If mem_addr = 2^ADDR_W-1 on that edge: → IDLE, rec_len = 2^ADDR_W, mem_addr = 0, done = 1.
  - rec_pulse and play_pulse are ignored.
- PLAY:
  - Same pacing as RECORD, but play_en is strobed instead of mem_we.
  - If mem_addr = rec_len-1 on the edge ending a strobe: → IDLE, mem_addr = 0, done = 1. rec_len is unchanged.
  - rec_pulse and play_pulse are ignored.
- stop_pulse in RECORD: → IDLE, rec_len = mem_addr + mem_we. A strobe already high in that cycle counts as completed. No new strobe is issued, even if the cycle is also a tick. mem_addr = 0, done = 1.
- stop_pulse in PLAY: → IDLE, mem_addr = 0, done = 1. rec_len is unchanged.
- A stop_pulse landing on the same edge as natural completion gives one done pulse. rec_len takes the same value by either rule.
- mem_we and play_en are never high together. Neither is ever high while state = IDLE.
- A reset mid-operation discards the recording length (rec_len = 0). Memory contents are not touched.

## Timing
- The pulse is sampled at edge E0; state changes at E0. The divider starts at 0 in the first cycle after E0.
- The first tick occurs SAMPLE_DIV cycles after E0. The first strobe is high in the following cycle, with mem_addr = 0.
- Strobes then repeat every SAMPLE_DIV cycles, each exactly one cycle wide.
- done is high in the cycle after the terminating edge, together with state = IDLE.
- Back-to-back: a rec_pulse or play_pulse arriving while done is high is accepted from IDLE.

## Test plan
- Reset: hold rst for 3 cycles mid-RECORD (SAMPLE_DIV=4, ADDR_W=3) → all outputs 0, state = 0, immediately on assertion (asynchronous).
- Full record (SAMPLE_DIV=4, ADDR_W=3), rec_pulse → 8 mem_we strobes at addresses 0..7, spaced 4 cycles apart, first strobe 5 cycles after the pulse → rec_len = 8, done one cycle, state = 0.
- Partial record, stop_pulse during the 4th strobe cycle (addr 3) → rec_len = 4, no further mem_we, done = 1.
- Playback after the partial record, play_pulse → play_en strobes at addresses 0..3 only, then IDLE with done. rec_len still 4.
- play_pulse after reset (rec_len = 0) → state stays 0, no strobes, no done.
- Simultaneous rec_pulse + play_pulse + stop_pulse in IDLE → no change. rec_pulse + play_pulse in IDLE → RECORD. play_pulse/rec_pulse in RECORD/PLAY → ignored, strobe spacing undisturbed.
